// File: rtl/arbiter_1_to_n_response_memory.sv
// Return-path demultiplexer: one memory response stream fanned out by
// destination index into per-receiver FIFOs, each drained by its own rd_en.

package arbiter_1_to_n_response_memory_pkg;
   typedef struct packed {
      logic [7:0] id_module;
   } MemoryPacketRouteAddress;

   typedef struct packed {
      MemoryPacketRouteAddress from;
      MemoryPacketRouteAddress to;
   } MemoryPacketRoute;

   typedef struct packed {
      MemoryPacketRoute route;
   } MemoryPacketMeta;

   typedef struct packed {
      MemoryPacketMeta meta;
      logic [31:0]     data;
   } MemoryPacketResponsePayload;

   typedef struct packed {
      logic                       valid;
      MemoryPacketResponsePayload payload;
   } MemoryPacketResponse;

   typedef struct packed {
      logic empty;
      logic prog_full;
   } FIFOStateSignalsOutput;

   typedef struct packed {
      logic rd_en;
   } FIFOStateSignalsInput;
endpackage

// Synchronous FIFO with registered read data and a one-cycle reset-busy flag.
module arbiter_1_to_n_response_memory_fifo #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned THRESH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             empty,
   output logic             prog_full,
   output logic             rst_busy
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full    = (r_count == DEPTH_C);
   assign empty     = (r_count == '0);
   assign prog_full = (r_count >= THRESH_C);
   assign w_push    = wr_en & ~w_full & ~rst_busy;
   assign w_pop     = rd_en & ~empty;

   // pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // storage array, contents are not reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   // registered read data
   always_ff @(posedge clk) begin
      if (w_pop) dout <= r_mem[r_rd_ptr];
   end

   // read-data qualifier
   always_ff @(posedge clk) begin
      if (rst) dout_valid <= 1'b0;
      else     dout_valid <= w_pop;
   end

   // busy for one cycle past reset so no write lands mid-initialisation
   always_ff @(posedge clk) begin
      rst_busy <= rst;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && w_full));
endmodule

module arbiter_1_to_n_response_memory
   import arbiter_1_to_n_response_memory_pkg::*;
#(
   parameter int unsigned NUM_MEMORY_RECEIVER  = 2,
   parameter int unsigned FIFO_RESPONSE_DEPTH  = 32,
   parameter int unsigned PROG_THRESH          = 16,
   parameter int unsigned FIFO_RECEIVER_DEPTH  = 16,
   parameter int unsigned RECEIVER_PROG_THRESH = 12
) (
   input  logic                                            ap_clk,
   input  logic                                            areset,
   input  MemoryPacketResponse                             response_in,
   output FIFOStateSignalsOutput                           fifo_response_signals_out,
   input  FIFOStateSignalsInput  [NUM_MEMORY_RECEIVER-1:0] fifo_response_signals_in,
   output MemoryPacketResponse   [NUM_MEMORY_RECEIVER-1:0] response_out,
   output FIFOStateSignalsOutput [NUM_MEMORY_RECEIVER-1:0] fifo_response_signals_out_rx,
   output logic                                            dest_error_out,
   output logic [15:0]                                     drop_count_out,
   output logic                                            fifo_setup_signal
);
   localparam int unsigned    IDX_W = $clog2(NUM_MEMORY_RECEIVER);
   localparam int unsigned    PW    = $bits(MemoryPacketResponsePayload);
   localparam logic [IDX_W:0] NRX   = (IDX_W+1)'(NUM_MEMORY_RECEIVER);

   logic                             r_rst;
   logic                             w_rst;
   logic                             r_in_valid;
   MemoryPacketResponsePayload       r_in_payload;
   logic                             w_in_rd_en;
   MemoryPacketResponsePayload       w_in_dout;
   logic                             w_in_dout_valid;
   logic                             w_in_empty;
   logic                             w_in_prog_full;
   logic                             w_in_busy;
   logic                             r_dmx_valid;
   logic [IDX_W-1:0]                 r_dmx_idx;
   MemoryPacketResponsePayload       r_dmx_payload;
   logic                             w_drop;
   logic [NUM_MEMORY_RECEIVER-1:0]   r_rd_en;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_wr_en;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_rd_en;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_empty;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_prog_full;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_dout_valid;
   logic [NUM_MEMORY_RECEIVER-1:0]   w_rx_busy;
   MemoryPacketResponsePayload       w_rx_dout [NUM_MEMORY_RECEIVER];

   // areset acts immediately and is held one extra cycle by its registered copy
   assign w_rst = areset | r_rst;

   // registered copy of the external reset
   always_ff @(posedge ap_clk) begin
      r_rst <= areset;
   end

   // head destination is unknown before the pop, so any full-ish receiver stalls all
   assign w_in_rd_en = ~w_in_empty & ~(|w_rx_prog_full);
   assign w_drop     = r_dmx_valid & ({1'b0, r_dmx_idx} >= NRX);

   // input capture stage; traffic is refused while FIFOs initialise
   always_ff @(posedge ap_clk) begin
      r_in_payload <= response_in.payload;
      if (w_rst) r_in_valid <= 1'b0;
      else       r_in_valid <= response_in.valid & ~fifo_setup_signal;
   end

   arbiter_1_to_n_response_memory_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_RESPONSE_DEPTH),
      .THRESH(PROG_THRESH)
   ) u_in_fifo (
      .clk       (ap_clk),
      .rst       (w_rst),
      .wr_en     (r_in_valid),
      .din       (r_in_payload),
      .rd_en     (w_in_rd_en),
      .dout      (w_in_dout),
      .dout_valid(w_in_dout_valid),
      .empty     (w_in_empty),
      .prog_full (w_in_prog_full),
      .rst_busy  (w_in_busy)
   );

   // demux stage: popped entry registered with its decoded destination
   always_ff @(posedge ap_clk) begin
      r_dmx_idx     <= w_in_dout.meta.route.to.id_module[IDX_W-1:0];
      r_dmx_payload <= w_in_dout;
      if (w_rst) r_dmx_valid <= 1'b0;
      else       r_dmx_valid <= w_in_dout_valid;
   end

   // out-of-range destinations are dropped, flagged and counted
   always_ff @(posedge ap_clk) begin
      if (w_rst) begin
         dest_error_out <= 1'b0;
         drop_count_out <= '0;
      end else if (w_drop) begin
         dest_error_out <= 1'b1;
         if (drop_count_out != '1) drop_count_out <= drop_count_out + 16'd1;
      end
   end

   // per-receiver write select and read gating
   always_comb begin
      w_rx_wr_en = '0;
      w_rx_rd_en = '0;
      for (int unsigned i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
         w_rx_wr_en[i] = r_dmx_valid & (r_dmx_idx == IDX_W'(i));
         w_rx_rd_en[i] = r_rd_en[i] & ~w_rx_empty[i];
      end
   end

   for (genvar g = 0; g < NUM_MEMORY_RECEIVER; g++) begin : g_rx
      arbiter_1_to_n_response_memory_fifo #(
         .WIDTH (PW),
         .DEPTH (FIFO_RECEIVER_DEPTH),
         .THRESH(RECEIVER_PROG_THRESH)
      ) u_rx_fifo (
         .clk       (ap_clk),
         .rst       (w_rst),
         .wr_en     (w_rx_wr_en[g]),
         .din       (r_dmx_payload),
         .rd_en     (w_rx_rd_en[g]),
         .dout      (w_rx_dout[g]),
         .dout_valid(w_rx_dout_valid[g]),
         .empty     (w_rx_empty[g]),
         .prog_full (w_rx_prog_full[g]),
         .rst_busy  (w_rx_busy[g])
      );
   end

   // per-receiver output register, status register and rd_en capture
   always_ff @(posedge ap_clk) begin
      for (int unsigned i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
         response_out[i].payload <= w_rx_dout[i];
         if (w_rst) begin
            response_out[i].valid           <= 1'b0;
            fifo_response_signals_out_rx[i] <= '{empty: 1'b1, prog_full: 1'b0};
            r_rd_en[i]                      <= 1'b0;
         end else begin
            response_out[i].valid           <= w_rx_dout_valid[i];
            fifo_response_signals_out_rx[i] <= '{empty: w_rx_empty[i], prog_full: w_rx_prog_full[i]};
            r_rd_en[i]                      <= fifo_response_signals_in[i].rd_en;
         end
      end
   end

   // upstream status and FIFO initialisation flag
   always_ff @(posedge ap_clk) begin
      if (w_rst) begin
         fifo_response_signals_out <= '{empty: 1'b1, prog_full: 1'b0};
         fifo_setup_signal         <= 1'b1;
      end else begin
         fifo_response_signals_out <= '{empty: w_in_empty, prog_full: w_in_prog_full};
         fifo_setup_signal         <= w_in_busy | (|w_rx_busy);
      end
   end
endmodule

// File: tb/tb_arbiter_1_to_n_response_memory.sv
// Bench for the 1-to-N response demux: per-destination expectation queues,
// a drop counter model, and a negedge compare process on every output.

module tb_arbiter_1_to_n_response_memory;
   import arbiter_1_to_n_response_memory_pkg::*;

   localparam int N = 3;

   logic                         clk = 1'b0;
   logic                         areset;
   MemoryPacketResponse          response_in;
   FIFOStateSignalsOutput        st_out;
   FIFOStateSignalsInput [N-1:0] rd_in;
   MemoryPacketResponse  [N-1:0] resp_out;
   FIFOStateSignalsOutput [N-1:0] st_rx;
   logic                         dest_err;
   logic [15:0]                  drop_cnt;
   logic                         setup;

   always #5 clk = ~clk;

   arbiter_1_to_n_response_memory #(
      .NUM_MEMORY_RECEIVER (N),
      .FIFO_RESPONSE_DEPTH (32),
      .PROG_THRESH         (16),
      .FIFO_RECEIVER_DEPTH (16),
      .RECEIVER_PROG_THRESH(12)
   ) dut (
      .ap_clk                      (clk),
      .areset                      (areset),
      .response_in                 (response_in),
      .fifo_response_signals_out   (st_out),
      .fifo_response_signals_in    (rd_in),
      .response_out                (resp_out),
      .fifo_response_signals_out_rx(st_rx),
      .dest_error_out              (dest_err),
      .drop_count_out              (drop_cnt),
      .fifo_setup_signal           (setup)
   );

   int n_checks = 0;
   int n_pass   = 0;
   MemoryPacketResponsePayload exp_q [N][$];
   int delivered [N];
   int model_drops = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // every valid output must be the oldest outstanding packet for that receiver
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (resp_out[i].valid === 1'b1) begin
            chk($sformatf("rx%0d_valid_expected", i), 64'(exp_q[i].size() != 0), 64'd1);
            if (exp_q[i].size() != 0) begin
               chk($sformatf("rx%0d_payload", i), 64'(resp_out[i].payload), 64'(exp_q[i].pop_front()));
               delivered[i]++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) rd_in[i].rd_en = m[i];
   endtask

   // present one packet and record where the rules say it must end up
   task automatic drive(input logic [7:0] id, input logic [31:0] data);
      MemoryPacketResponse p;
      logic [1:0] d;
      p = '0;
      p.valid = 1'b1;
      p.payload.meta.route.to.id_module   = id;
      p.payload.meta.route.from.id_module = 8'($urandom);
      p.payload.data = data;
      response_in = p;
      d = id[1:0];
      if (int'(d) < N) exp_q[d].push_back(p.payload);
      else             model_drops++;
   endtask

   task automatic idle();
      response_in.valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] id, input logic [31:0] data);
      int w = 0;
      while (st_out.prog_full && w < 200) begin
         idle();
         step();
         w++;
      end
      if (st_out.prog_full) chk("upstream_wait_bound", 64'(st_out.prog_full), 64'd0);
      drive(id, data);
      step();
   endtask

   function automatic int queued();
      int s = 0;
      for (int i = 0; i < N; i++) s += exp_q[i].size();
      return s;
   endfunction

   task automatic drain();
      int w = 0;
      idle();
      set_rd('1);
      while (queued() != 0 && w < 1000) begin
         step();
         w++;
      end
      chk("drain_outstanding", 64'(queued()), 64'd0);
      repeat (10) step();
   endtask

   int base [N];
   task automatic snap();
      for (int i = 0; i < N; i++) base[i] = delivered[i];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int lat;
      for (int i = 0; i < N; i++) delivered[i] = 0;
      areset      = 1'b1;
      response_in = '0;
      set_rd('0);

      // reset values
      repeat (4) step();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset_rx%0d_valid", i), 64'(resp_out[i].valid), 64'd0);
         chk($sformatf("reset_rx%0d_status", i), 64'(st_rx[i]), 64'b10);
      end
      chk("reset_in_status", 64'(st_out), 64'b10);
      chk("reset_dest_error", 64'(dest_err), 64'd0);
      chk("reset_drop_count", 64'(drop_cnt), 64'd0);
      chk("reset_setup_high", 64'(setup), 64'd1);
      areset = 1'b0;
      w = 0;
      while (setup && w < 50) begin step(); w++; end
      chk("setup_falls", 64'(setup), 64'd0);

      // single packet latency to receiver 1
      set_rd('1);
      repeat (2) step();
      snap();
      drive(8'd1, 32'hA5A5_0001);
      step();
      idle();
      lat = 1;
      while (resp_out[1].valid !== 1'b1 && lat < 20) begin step(); lat++; end
      chk("single_latency", 64'(lat), 64'd7);
      drain();
      chk("single_rx0_count", 64'(delivered[0] - base[0]), 64'd0);
      chk("single_rx1_count", 64'(delivered[1] - base[1]), 64'd1);

      // interleaved destinations
      snap();
      for (int k = 0; k < 8; k++) send(8'(k % 2), 32'hC000_0000 + 32'(k));
      drain();
      chk("interleave_rx0_count", 64'(delivered[0] - base[0]), 64'd4);
      chk("interleave_rx1_count", 64'(delivered[1] - base[1]), 64'd4);

      // backpressure on receiver 0: 14 land in rx0, 16 remain in the input FIFO
      set_rd(3'b110);
      repeat (3) step();
      snap();
      for (int k = 0; k < 30; k++) send(8'd0, 32'hB000_0000 + 32'(k));
      idle();
      repeat (12) step();
      chk("bp_rx0_prog_full", 64'(st_rx[0].prog_full), 64'd1);
      chk("bp_in_prog_full", 64'(st_out.prog_full), 64'd1);
      chk("bp_rx0_held", 64'(delivered[0] - base[0]), 64'd0);
      drain();
      chk("bp_rx0_count", 64'(delivered[0] - base[0]), 64'd30);

      // out-of-range destination
      snap();
      send(8'd3, 32'hDEAD_0003);
      send(8'd3, 32'hDEAD_0103);
      send(8'd1, 32'h1111_0001);
      send(8'd0, 32'h1111_0000);
      drain();
      chk("badid_dest_error", 64'(dest_err), 64'd1);
      chk("badid_drop_count", 64'(drop_cnt), 64'd2);
      chk("badid_rx0_count", 64'(delivered[0] - base[0]), 64'd1);
      chk("badid_rx1_count", 64'(delivered[1] - base[1]), 64'd1);

      // reset with traffic in flight
      for (int k = 0; k < 10; k++) send(8'($urandom_range(0, 2)), $urandom);
      idle();
      areset = 1'b1;
      step();
      for (int i = 0; i < N; i++) exp_q[i].delete();
      model_drops = 0;
      repeat (3) step();
      chk("midreset_setup_high", 64'(setup), 64'd1);
      areset = 1'b0;
      w = 0;
      while (setup && w < 50) begin step(); w++; end
      chk("midreset_setup_falls", 64'(setup), 64'd0);
      chk("midreset_drop_count", 64'(drop_cnt), 64'd0);
      chk("midreset_dest_error", 64'(dest_err), 64'd0);
      chk("midreset_in_status", 64'(st_out), 64'b10);
      snap();
      send(8'd2, 32'h5EED_0002);
      drain();
      chk("midreset_rx2_count", 64'(delivered[2] - base[2]), 64'd1);

      // randomized traffic with random receiver stalls
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) rd_in[i].rd_en = ($urandom_range(0, 3) != 0);
         if (!st_out.prog_full && $urandom_range(0, 3) != 0)
            drive(8'($urandom_range(0, 3)), $urandom);
         else
            idle();
         step();
      end
      drain();
      chk("random_drop_count", 64'(drop_cnt), 64'(model_drops));
      chk("random_dest_error", 64'(dest_err), 64'(model_drops != 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
